ber_phase_scan: RTL
===================

Name: ber_phase_scan

Overview:
- Sequencer that selects the polyphase sampling phase fed to the BER checkers.
- Steps the phase select through all N_PHASES values. For each phase it waits a settle interval, then counts comparison errors over a fixed window of symbol strobes.
- Locks onto the phase with the fewest errors and keeps monitoring it; rescans when the error count degrades.
- Sits between the clock/4 enable generator (symbol strobe) and the BER_I/BER_Q phase-select inputs. Replaces the manual phase switches.

Parameters:
- N_PHASES, 4, number of polyphase sampling phases to scan.
- NB_SEL, 2, width of the phase select; 2^NB_SEL >= N_PHASES.
- NB_COUNT, 9, width of the error counter and symbol counter.
- N_WINDOW, 511, symbol strobes counted per measurement window (one PRBS9 period); 1..2^NB_COUNT-1.
- N_SETTLE, 8, symbol strobes discarded after each phase change (pipeline flush); 1..255.
- RELOCK_THR, 32, error count per window in LOCKED above which a rescan starts.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous active-high reset.
- i_enable  in  1  global run; low freezes all state and counters.
- i_start  in  1  one-cycle pulse; starts or restarts a scan.
- i_sym_valid  in  1  symbol strobe, one cycle per symbol (clock/4 enable).
- i_error  in  1  mismatch flag, qualified by i_sym_valid.
- o_phase_sel  out  NB_SEL  phase select driven to the BER checkers.
- o_meas_active  out  1  high while in MEASURE or LOCKED.
- o_best_phase  out  NB_SEL  best phase found by the last completed scan.
- o_best_errors  out  NB_COUNT  error count of the best phase.
- o_lock  out  1  high in LOCKED.
- o_relock  out  1  one-cycle pulse when LOCKED degrades into a rescan.

Behaviour:
- Reset, asynchronous, to IDLE:
  - o_phase_sel = 0, o_best_phase = 0.
  - o_best_errors = all ones.
  - o_lock = 0, o_meas_active = 0, o_relock = 0.
  - All counters = 0.
- All outputs are registered.
- i_enable = 0 holds every register. Strobes and i_start are ignored.
- IDLE: on i_start, go to SETTLE with phase = 0, best_errors = all ones, sym_cnt = 0.
- SETTLE:
  - Count i_sym_valid.
  - On the N_SETTLE-th strobe, go to MEASURE; clear sym_cnt and err_cnt.
- MEASURE:
  - On each strobe, sym_cnt increments.
  - If i_error is also high, err_cnt increments, saturating at 2^NB_COUNT-1.
  - On the strobe that makes sym_cnt = N_WINDOW (that strobe's error included), go to COMPARE.
- COMPARE (exactly 1 cycle):
  - If err_cnt < best_errors (strict), load best_phase = phase and best_errors = err_cnt. Ties keep the lower phase.
  - If phase = N_PHASES-1, go to LOCKED and set o_phase_sel = best_phase, using the value updated this cycle.
  - Otherwise phase+1, go to SETTLE.
- Scan latency with continuous strobes every 4 cycles: N_PHASES*(N_SETTLE+N_WINDOW) strobes plus one COMPARE cycle per phase.
- LOCKED:
  - o_lock = 1. Measures windows of N_WINDOW strobes with the same counting rules.
  - At window end, if err_cnt > RELOCK_THR: pulse o_relock, drop o_lock, restart the scan at phase 0 in SETTLE.
  - If err_cnt <= RELOCK_THR, clear the counters and continue in LOCKED.
  - o_best_* are not modified in LOCKED.
- i_start in any non-IDLE state restarts the scan as from IDLE and drops o_lock the next cycle. This takes priority over a window end in the same cycle.
- Strobes arriving during COMPARE are dropped. The strobe spacing is >= 2 clocks by contract.

Decomposition:
- Shared package:
  - State encoding: IDLE, SETTLE, MEASURE, COMPARE, LOCKED.
  - Defaults for N_WINDOW and N_SETTLE.
  - Localparam for the saturation value (2^NB_COUNT-1).
- One natural sub-module: ber_window_counter.
  - Contains the symbol counter and the saturating error counter.
  - Interface: clear, strobe, and error inputs; window_done output.
  - Reused by MEASURE and LOCKED.
- The FSM and best-phase register stay in the top.

Test Plan:
- Reset mid-MEASURE (phase 2) -> all outputs return to reset values within the same cycle, no clock edge needed; o_best_errors = 511.
- Defaults; i_error = 1 on every strobe except phase 2, which has 3 errors -> o_lock = 1, o_best_phase = 2, o_best_errors = 3, o_phase_sel = 2.
- Phases 1 and 3 both have 0 errors, others 511 -> o_best_phase = 1 (tie keeps lower).
- In LOCKED, inject 33 errors in one window -> o_relock pulses for 1 cycle, o_lock = 0, o_phase_sel = 0, state SETTLE. With 32 errors, the block stays locked.
- Drop i_enable for 100 cycles mid-SETTLE with strobes running -> settle count unchanged; resumes and completes after the remaining strobes.
- All strobes flagged in phase 0 -> err_cnt saturates at 511, no wrap; i_start during phase 3 -> scan restarts at phase 0.

Source files
------------

// File: rtl/ber_phase_scan_pkg.sv
// ber_phase_scan_pkg: shared state encoding, parameter defaults and helpers for the phase scanner.
//   Contents: state_t and ST_* state constants, DEF_* defaults, sat_max() saturation helper.
package ber_phase_scan_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETTLE  = 3'd1;
    localparam state_t ST_MEASURE = 3'd2;
    localparam state_t ST_COMPARE = 3'd3;
    localparam state_t ST_LOCKED  = 3'd4;

    localparam int DEF_NB_COUNT   = 9;
    localparam int DEF_N_WINDOW   = 511;
    localparam int DEF_N_SETTLE   = 8;
    localparam int DEF_RELOCK_THR = 32;

    // Saturation value of an nb-bit counter (2^nb - 1).
    localparam int ERR_SAT = (1 << DEF_NB_COUNT) - 1;

    function automatic int sat_max(input int nb);
        return (1 << nb) - 1;
    endfunction

endpackage

// File: rtl/ber_window_counter.sv
// ber_window_counter: symbol counter plus saturating error counter for one measurement window.
//   clock, i_reset : clock, asynchronous active-high reset
//   clear          : zero both counters (wins over strobe)
//   strobe         : qualified symbol strobe to count
//   error          : mismatch flag, counted only with strobe
//   err_cnt        : registered error count of the window so far
//   err_next       : error count including the current strobe
//   window_done    : high on the strobe that completes the window
module ber_window_counter
    import ber_phase_scan_pkg::*;
#(
    parameter int NB_COUNT = DEF_NB_COUNT,
    parameter int N_WINDOW = DEF_N_WINDOW
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                clear,
    input  logic                strobe,
    input  logic                error,
    output logic [NB_COUNT-1:0] err_cnt,
    output logic [NB_COUNT-1:0] err_next,
    output logic                window_done
);

    localparam logic [NB_COUNT-1:0] SAT  = NB_COUNT'(sat_max(NB_COUNT));
    localparam logic [NB_COUNT-1:0] LAST = NB_COUNT'(N_WINDOW - 1);

    logic [NB_COUNT-1:0] sym_cnt;

    always_comb begin
        err_next    = (strobe && error && err_cnt != SAT) ? err_cnt + 1'b1 : err_cnt;
        window_done = strobe && sym_cnt == LAST;
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            sym_cnt <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            sym_cnt <= '0;
            err_cnt <= '0;
        end else if (strobe) begin
            sym_cnt <= sym_cnt + 1'b1;
            err_cnt <= err_next;
        end
    end

endmodule

// File: rtl/ber_phase_scan.sv
// ber_phase_scan: scans polyphase sampling phases, locks onto the one with fewest BER errors.
//   clock, i_reset : clock, asynchronous active-high reset
//   i_enable       : global run, low freezes all state
//   i_start        : one-cycle pulse, starts or restarts a scan
//   i_sym_valid    : symbol strobe
//   i_error        : mismatch flag qualified by i_sym_valid
//   o_phase_sel    : phase select to the BER checkers
//   o_meas_active  : high in MEASURE or LOCKED
//   o_best_phase   : best phase of the last completed scan
//   o_best_errors  : error count of that phase
//   o_lock         : high in LOCKED
//   o_relock       : one-cycle pulse when LOCKED degrades into a rescan
module ber_phase_scan
    import ber_phase_scan_pkg::*;
#(
    parameter int N_PHASES   = 4,
    parameter int NB_SEL     = 2,
    parameter int NB_COUNT   = DEF_NB_COUNT,
    parameter int N_WINDOW   = DEF_N_WINDOW,
    parameter int N_SETTLE   = DEF_N_SETTLE,
    parameter int RELOCK_THR = DEF_RELOCK_THR
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_sym_valid,
    input  logic                i_error,
    output logic [NB_SEL-1:0]   o_phase_sel,
    output logic                o_meas_active,
    output logic [NB_SEL-1:0]   o_best_phase,
    output logic [NB_COUNT-1:0] o_best_errors,
    output logic                o_lock,
    output logic                o_relock
);

    localparam logic [NB_COUNT-1:0] ERR_ALL     = NB_COUNT'(sat_max(NB_COUNT));
    localparam logic [NB_SEL-1:0]   LAST_PHASE  = NB_SEL'(N_PHASES - 1);
    localparam logic [7:0]          LAST_SETTLE = 8'(N_SETTLE - 1);

    state_t              state, state_nxt;
    logic [7:0]          settle_cnt, settle_nxt;
    logic [NB_SEL-1:0]   phase_nxt, best_phase_nxt;
    logic [NB_COUNT-1:0] best_err_nxt, err_cnt, err_next;
    logic                counting, win_strobe, win_clear, window_done, degrade, restart, better;

    // The window counter only runs in MEASURE/LOCKED and is held clear elsewhere,
    // so every measurement starts from zero and COMPARE-cycle strobes are dropped.
    assign counting   = state == ST_MEASURE || state == ST_LOCKED;
    assign win_strobe = i_enable && i_sym_valid && counting;
    assign degrade    = state == ST_LOCKED && window_done && int'(err_next) > RELOCK_THR;
    assign restart    = i_start || degrade;
    assign win_clear  = i_enable && (restart || !counting || (state == ST_LOCKED && window_done));
    assign better     = err_cnt < o_best_errors;

    ber_window_counter #(
        .NB_COUNT (NB_COUNT),
        .N_WINDOW (N_WINDOW)
    ) u_counter (
        .clock       (clock),
        .i_reset     (i_reset),
        .clear       (win_clear),
        .strobe      (win_strobe),
        .error       (i_error),
        .err_cnt     (err_cnt),
        .err_next    (err_next),
        .window_done (window_done)
    );

    always_comb begin
        state_nxt      = state;
        phase_nxt      = o_phase_sel;
        settle_nxt     = settle_cnt;
        best_phase_nxt = o_best_phase;
        best_err_nxt   = o_best_errors;
        if (restart) begin
            state_nxt      = ST_SETTLE;
            phase_nxt      = '0;
            settle_nxt     = '0;
            best_phase_nxt = '0;
            best_err_nxt   = ERR_ALL;
        end else begin
            case (state)
                ST_SETTLE: if (i_sym_valid) begin
                    settle_nxt = settle_cnt == LAST_SETTLE ? 8'd0 : settle_cnt + 1'b1;
                    state_nxt  = settle_cnt == LAST_SETTLE ? ST_MEASURE : ST_SETTLE;
                end
                ST_MEASURE: state_nxt = window_done ? ST_COMPARE : ST_MEASURE;
                ST_COMPARE: begin
                    // Strict less-than keeps the lower phase on ties; the lock
                    // target uses the best value updated in this same cycle.
                    best_phase_nxt = better ? o_phase_sel : o_best_phase;
                    best_err_nxt   = better ? err_cnt : o_best_errors;
                    state_nxt      = o_phase_sel == LAST_PHASE ? ST_LOCKED : ST_SETTLE;
                    phase_nxt      = o_phase_sel == LAST_PHASE ? best_phase_nxt : o_phase_sel + 1'b1;
                end
                ST_LOCKED: state_nxt = ST_LOCKED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            o_phase_sel   <= '0;
            o_best_phase  <= '0;
            o_best_errors <= ERR_ALL;
            o_lock        <= 1'b0;
            o_meas_active <= 1'b0;
            o_relock      <= 1'b0;
        end else if (i_enable) begin
            state         <= state_nxt;
            settle_cnt    <= settle_nxt;
            o_phase_sel   <= phase_nxt;
            o_best_phase  <= best_phase_nxt;
            o_best_errors <= best_err_nxt;
            o_lock        <= state_nxt == ST_LOCKED;
            o_meas_active <= state_nxt == ST_MEASURE || state_nxt == ST_LOCKED;
            o_relock      <= degrade && !i_start;
        end
    end

endmodule
